// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin register-file write arbiter with clear sweep
module regfile_wr_arbiter #(
    parameter int A = 4,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         alu_req,
    input  logic         acc_req,
    input  logic         mem_req,
    input  logic [A-1:0] alu_addr,
    input  logic [A-1:0] acc_addr,
    input  logic [A-1:0] mem_addr,
    input  logic [W-1:0] alu_data,
    input  logic [W-1:0] acc_data,
    input  logic [W-1:0] mem_data,
    output logic         alu_gnt,
    output logic         acc_gnt,
    output logic         mem_gnt,
    input  logic         clear_start,
    output logic         clear_busy,
    output logic         clear_done,
    output logic         Write_En,
    output logic         from_ALU,
    output logic         from_Acc,
    output logic         from_Mem,
    output logic [A-1:0] address,
    output logic [W-1:0] wr_data
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_ACC = 2'd1;
    localparam logic [1:0] SRC_MEM = 2'd2;

    state_t       state;
    logic [A-1:0] clr_cnt;
    logic [1:0]   rr_ptr;
    logic         arb_en;
    logic [2:0]   gnt_vec;
    logic [A-1:0] gnt_addr;
    logic [W-1:0] gnt_data;

    // rr_ptr holds the last granted source; search starts at the one after it.
    always_comb begin
        arb_en  = Reset && (state == IDLE) && !clear_start;
        gnt_vec = 3'b000;
        if (arb_en) begin
            case (rr_ptr)
                SRC_ALU: begin
                    if      (acc_req) gnt_vec = 3'b010;
                    else if (mem_req) gnt_vec = 3'b100;
                    else if (alu_req) gnt_vec = 3'b001;
                end
                SRC_ACC: begin
                    if      (mem_req) gnt_vec = 3'b100;
                    else if (alu_req) gnt_vec = 3'b001;
                    else if (acc_req) gnt_vec = 3'b010;
                end
                default: begin
                    if      (alu_req) gnt_vec = 3'b001;
                    else if (acc_req) gnt_vec = 3'b010;
                    else if (mem_req) gnt_vec = 3'b100;
                end
            endcase
        end
    end

    always_comb begin
        gnt_addr = alu_addr;
        gnt_data = alu_data;
        if (gnt_vec[1]) begin
            gnt_addr = acc_addr;
            gnt_data = acc_data;
        end else if (gnt_vec[2]) begin
            gnt_addr = mem_addr;
            gnt_data = mem_data;
        end
    end

    assign alu_gnt = gnt_vec[0];
    assign acc_gnt = gnt_vec[1];
    assign mem_gnt = gnt_vec[2];

    // clr_cnt is the next sweep address; it returns to 0 after the last write,
    // which marks the final CLEAR cycle.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            rr_ptr     <= SRC_MEM;
            Write_En   <= 1'b0;
            from_ALU   <= 1'b0;
            from_Acc   <= 1'b0;
            from_Mem   <= 1'b0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
            address    <= '0;
            wr_data    <= '0;
        end else begin
            Write_En   <= 1'b0;
            from_ALU   <= 1'b0;
            from_Acc   <= 1'b0;
            from_Mem   <= 1'b0;
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state      <= CLEAR;
                        clear_busy <= 1'b1;
                        Write_En   <= 1'b1;
                        from_ALU   <= 1'b1;
                        address    <= '0;
                        wr_data    <= '0;
                        clr_cnt    <= A'(1);
                    end else if (|gnt_vec) begin
                        Write_En <= 1'b1;
                        from_ALU <= gnt_vec[0];
                        from_Acc <= gnt_vec[1];
                        from_Mem <= gnt_vec[2];
                        address  <= gnt_addr;
                        wr_data  <= gnt_data;
                        if (gnt_vec[0])      rr_ptr <= SRC_ALU;
                        else if (gnt_vec[1]) rr_ptr <= SRC_ACC;
                        else                 rr_ptr <= SRC_MEM;
                    end
                end
                default: begin
                    if (clr_cnt == '0) begin
                        state      <= IDLE;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        Write_En <= 1'b1;
                        from_ALU <= 1'b1;
                        address  <= clr_cnt;
                        wr_data  <= '0;
                        clr_cnt  <= clr_cnt + A'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - scoreboard bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

    localparam int A = 4;
    localparam int W = 8;
    localparam int N = 1 << A;

    logic         clk = 1'b0;
    logic         Reset;
    logic         alu_req, acc_req, mem_req;
    logic [A-1:0] alu_addr, acc_addr, mem_addr;
    logic [W-1:0] alu_data, acc_data, mem_data;
    logic         alu_gnt, acc_gnt, mem_gnt;
    logic         clear_start, clear_busy, clear_done;
    logic         Write_En, from_ALU, from_Acc, from_Mem;
    logic [A-1:0] address;
    logic [W-1:0] wr_data;

    regfile_wr_arbiter #(.A(A), .W(W)) dut (
        .clk(clk), .Reset(Reset),
        .alu_req(alu_req), .acc_req(acc_req), .mem_req(mem_req),
        .alu_addr(alu_addr), .acc_addr(acc_addr), .mem_addr(mem_addr),
        .alu_data(alu_data), .acc_data(acc_data), .mem_data(mem_data),
        .alu_gnt(alu_gnt), .acc_gnt(acc_gnt), .mem_gnt(mem_gnt),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .Write_En(Write_En), .from_ALU(from_ALU), .from_Acc(from_Acc), .from_Mem(from_Mem),
        .address(address), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   gnt;
        logic         we;
        logic [2:0]   src;
        logic [A-1:0] addr;
        logic [W-1:0] data;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    // stimulus state: index 0=ALU, 1=Acc, 2=Mem
    logic [2:0]   req_v = '0;
    logic [A-1:0] addr_v [3];
    logic [W-1:0] data_v [3];
    logic         clr_v = 1'b0;
    logic         rst_v = 1'b0;
    int           last_g = -1;

    // reference model state
    int           m_last = 2;
    bit           m_clear = 1'b0;
    int           clr_q[$];
    logic         m_we = 0, m_busy = 0, m_done = 0;
    logic [2:0]   m_src = '0;
    logic [A-1:0] m_addr = '0;
    logic [W-1:0] m_data = '0;

    logic [W-1:0] rf_obs [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
        end
    endtask

    task automatic model_reset();
        m_last = 2; m_clear = 0; clr_q.delete();
        m_we = 0; m_busy = 0; m_done = 0; m_src = '0; m_addr = '0; m_data = '0;
    endtask

    // One clock cycle: drive inputs, predict this cycle's observation, advance model.
    task automatic cycle();
        exp_t         e;
        int           g;
        logic         n_we, n_busy, n_done;
        logic [2:0]   n_src;
        logic [A-1:0] n_addr;
        logic [W-1:0] n_data;
        alu_req = req_v[0]; acc_req = req_v[1]; mem_req = req_v[2];
        alu_addr = addr_v[0]; acc_addr = addr_v[1]; mem_addr = addr_v[2];
        alu_data = data_v[0]; acc_data = data_v[1]; mem_data = data_v[2];
        clear_start = clr_v;
        Reset = rst_v;
        g = -1;
        if (!rst_v) begin
            model_reset();
            e = '{gnt: 3'b0, we: 0, src: 3'b0, addr: '0, data: '0, busy: 0, done: 0};
        end else begin
            e = '{gnt: 3'b0, we: m_we, src: m_src, addr: m_addr, data: m_data, busy: m_busy, done: m_done};
            n_we = 0; n_src = '0; n_busy = m_busy; n_done = 0; n_addr = m_addr; n_data = m_data;
            if (m_clear) begin
                if (clr_q.size() > 0) begin
                    n_we = 1; n_src = 3'b001; n_addr = A'(clr_q.pop_front()); n_data = '0;
                end else begin
                    m_clear = 0; n_busy = 0; n_done = 1;
                end
            end else if (clr_v) begin
                m_clear = 1;
                clr_q.delete();
                for (int i = 1; i < N; i++) clr_q.push_back(i);
                n_we = 1; n_src = 3'b001; n_addr = '0; n_data = '0; n_busy = 1;
            end else begin
                for (int k = 1; k <= 3; k++) begin
                    int s;
                    s = (m_last + k) % 3;
                    if (g < 0 && req_v[s]) g = s;
                end
                if (g >= 0) begin
                    m_last = g;
                    n_we = 1; n_src = 3'(1 << g); n_addr = addr_v[g]; n_data = data_v[g];
                end
            end
            e.gnt = (g >= 0) ? 3'(1 << g) : 3'b000;
            m_we = n_we; m_src = n_src; m_busy = n_busy; m_done = n_done;
            m_addr = n_addr; m_data = n_data;
        end
        last_g = g;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cycles);
        int c;
        c = 0;
        while (req_v != 3'b000 && c < max_cycles) begin
            cycle();
            if (last_g >= 0) req_v[last_g] = 1'b0;
            c++;
        end
        chk("drain_bound", 32'(req_v), 32'h0);
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("gnt", 32'({mem_gnt, acc_gnt, alu_gnt}), 32'(mon_e.gnt));
            chk("write_en", 32'(Write_En), 32'(mon_e.we));
            chk("from_src", 32'({from_Mem, from_Acc, from_ALU}), 32'(mon_e.src));
            chk("address", 32'(address), 32'(mon_e.addr));
            chk("wr_data", 32'(wr_data), 32'(mon_e.data));
            chk("clear_busy", 32'(clear_busy), 32'(mon_e.busy));
            chk("clear_done", 32'(clear_done), 32'(mon_e.done));
        end
        if (Reset === 1'b1 && Write_En === 1'b1) rf_obs[address] = wr_data;
    end

    initial begin
        for (int i = 0; i < 3; i++) begin addr_v[i] = '0; data_v[i] = '0; end
        for (int i = 0; i < N; i++) rf_obs[i] = 'x;
        Reset = 1'b0; clear_start = 1'b0;
        alu_req = 0; acc_req = 0; mem_req = 0;
        alu_addr = '0; acc_addr = '0; mem_addr = '0;
        alu_data = '0; acc_data = '0; mem_data = '0;
        @(posedge clk); #1;

        // reset state, with pending requests that must not be granted
        rst_v = 0; req_v = 3'b111;
        cycle(); cycle();
        rst_v = 1; req_v = 3'b000;
        cycle();

        // three requesters in round-robin order
        req_v = 3'b111;
        addr_v[0] = 1; addr_v[1] = 2; addr_v[2] = 3;
        data_v[0] = 8'h11; data_v[1] = 8'h22; data_v[2] = 8'h33;
        drain(10);
        cycle();

        // lone requester back-to-back
        req_v = 3'b100; addr_v[2] = 5; data_v[2] = 8'hA5;
        repeat (4) cycle();
        req_v = 3'b000;
        cycle(); cycle();

        // same address from ALU and Acc right after reset: last write wins
        rst_v = 0; cycle(); rst_v = 1;
        req_v = 3'b011; addr_v[0] = 7; addr_v[1] = 7; data_v[0] = 8'h01; data_v[1] = 8'h02;
        drain(10);
        cycle(); cycle();
        chk("rf7_last_wins", 32'(rf_obs[7]), 32'h02);

        // clear with a simultaneous ALU request
        clr_v = 1; req_v = 3'b001; addr_v[0] = 9; data_v[0] = 8'h5A;
        cycle();
        clr_v = 0;
        drain(N + 8);
        cycle(); cycle();
        chk("rf9_after_clear", 32'(rf_obs[9]), 32'h5A);
        chk("rf15_cleared", 32'(rf_obs[N-1]), 32'h00);

        // reset mid-sweep, then a full fresh sweep
        clr_v = 1; cycle(); clr_v = 0;
        repeat (6) cycle();
        rst_v = 0; cycle(); rst_v = 1;
        cycle();
        clr_v = 1; cycle(); clr_v = 0;
        repeat (N + 3) cycle();

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            for (int s = 0; s < 3; s++) begin
                if (!req_v[s] && $urandom_range(0, 2) == 0) begin
                    req_v[s] = 1'b1;
                    addr_v[s] = A'($urandom);
                    data_v[s] = W'($urandom);
                end
            end
            clr_v = ($urandom_range(0, 49) == 0);
            rst_v = ($urandom_range(0, 299) != 0);
            cycle();
            if (last_g >= 0) req_v[last_g] = 1'b0;
        end
        rst_v = 1; clr_v = 0; req_v = 3'b000;
        cycle();
        @(negedge clk); #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter A, default 4, register address width (2**A registers).
REQ-002 SHALL have parameter W, default 8, register data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports alu_req / acc_req / mem_req  input  1 each  write request from the ALU, accumulator and data memory.
REQ-006 SHALL have ports alu_addr / acc_addr / mem_addr  input  A each  target register per requester.
REQ-007 SHALL have ports alu_data / acc_data / mem_data  input  W each  write data per requester.
REQ-008 SHALL have ports alu_gnt / acc_gnt / mem_gnt  output  1 each  one-cycle grant pulse.
REQ-009 SHALL have port clear_start  input  1  request to zero all registers.
REQ-010 SHALL have port clear_busy  output  1  high while the clear sweep runs.
REQ-011 SHALL have port clear_done  output  1  one-cycle pulse after the last clear write.
REQ-012 SHALL have ports Write_En, from_ALU, from_Acc, from_Mem  output  1 each  register-file write strobe and one-hot source select.
REQ-013 SHALL have port address  output  A  register-file write address.
REQ-014 SHALL have port wr_data  output  W  write data, fanned to all three register-file data inputs.

Function
REQ-015 SHALL implement FSM states IDLE and CLEAR; the reset state is IDLE.
REQ-016 In IDLE, SHALL grant at most one asserted request per cycle using round-robin order ALU -> Acc -> Mem -> ALU, starting after the last granted source.
REQ-017 SHALL assert exactly one gnt, combinationally, in the cycle of arbitration; the requester SHALL hold req/addr/data stable until it sees gnt.
REQ-018 SHALL register the granted write: in the cycle after gnt, Write_En=1, the matching from_* =1, address and wr_data equal to the granted requester's values (latency 1).
REQ-019 In cycles with no grant and no clear write, Write_En, from_ALU, from_Acc and from_Mem SHALL be 0; address and wr_data SHALL hold their previous values.
REQ-020 SHALL update the round-robin pointer only on a grant; a lone requester SHALL be granted every cycle it holds req (back-to-back throughput 1 write/cycle).
REQ-021 Requests to the same address from different sources SHALL be written in separate cycles in round-robin order; the last write wins.
REQ-022 clear_start sampled high in IDLE SHALL move to CLEAR on the next edge; no grant SHALL be issued in that cycle even if requests are pending.
REQ-023 In CLEAR, SHALL issue one write per cycle for addresses 0 .. 2**A-1 ascending, with wr_data=0, from_ALU=1, Write_En=1; clear_busy=1 throughout.
REQ-024 In CLEAR, all gnt outputs SHALL be 0 and clear_start SHALL be ignored.
REQ-025 After the write to address 2**A-1 is issued, SHALL return to IDLE and pulse clear_done for exactly one cycle; arbitration resumes that cycle.
REQ-026 A clear sweep SHALL take exactly 2**A write cycles; the address counter SHALL wrap to 0 on exit.
REQ-027 The round-robin pointer SHALL be unchanged by a clear sweep.

Reset
REQ-028 On Reset low, asynchronously: state IDLE, clear counter 0, round-robin pointer = Mem (so ALU has priority first), Write_En/from_*/clear_busy/clear_done=0, address=0, wr_data=0.
REQ-029 Reset asserted mid-sweep or mid-write SHALL abort immediately; no write SHALL be issued in the first edge after Reset deasserts unless a grant occurred the cycle before.
REQ-030 gnt outputs SHALL be 0 while Reset is low.

Verification
REQ-031 All three req high, addrs 1/2/3, data 0x11/0x22/0x33, held until granted -> gnts ALU, Acc, Mem in consecutive cycles; writes (1,0x11,ALU), (2,0x22,Acc), (3,0x33,Mem) one cycle after each gnt.
REQ-032 Only mem_req held high 4 cycles with addr 5, data 0xA5 -> mem_gnt high 4 cycles; Write_En/from_Mem high 4 cycles one cycle later, address 5.
REQ-033 clear_start and alu_req asserted together in IDLE -> no gnt; 16 writes addr 0..15 data 0x00 from_ALU; clear_done pulse; alu_gnt in the clear_done cycle.
REQ-034 ALU and Acc both write addr 7 (0x01, 0x02) from reset -> ALU first, Acc second; final register value 0x02.
REQ-035 Reset pulled low at clear address 6 -> all outputs 0 immediately; after release, state IDLE, clear_busy 0, next clear_start sweeps from address 0.
